// File: rtl/lfsr_pkg.sv
// Shared definitions for the Galois LFSR pattern generator and its sequence checker.
// Holds the checker state encoding, default polynomial and the next-bit predictor.
package lfsr_pkg;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StHunt   = 2'd1,
    StLocked = 2'd2
  } lfsr_state_e;

  localparam int unsigned LfsrLength = 8;
  localparam logic [1:LfsrLength] LfsrTaps = 8'b1100_1111;

  // Widest history the predictor accepts; callers zero-pad shorter ones.
  localparam int unsigned LfsrMaxLength = 64;
  localparam logic [LfsrMaxLength:1] LfsrOne = LfsrMaxLength'(1);

  // pred = hist[len] ^ XOR of hist[m] for taps[m] set, m < len.
  function automatic logic lfsr_predict(input logic [LfsrMaxLength:1] hist,
                                        input logic [LfsrMaxLength:1] taps,
                                        input int unsigned len);
    logic [LfsrMaxLength:1] top;
    logic [LfsrMaxLength:1] below;
    top   = LfsrOne << (len - 1);
    below = top - LfsrOne;
    return ^(hist & ((taps & below) | top));
  endfunction

endpackage

// File: rtl/lfsr_sequence_checker_history_predictor.sv
// History shift register for the sequence checker and the predicted next bit.
// In flywheel mode the prediction is fed back so a line error is not replicated.
module lfsr_history_predictor
  import lfsr_pkg::*;
#(
  parameter int unsigned      Length          = LfsrLength,
  parameter logic [1:Length]  Tap_Coefficient = LfsrTaps
) (
  input  logic Clock,
  input  logic Reset,
  input  logic shift_en,
  input  logic use_pred,
  input  logic bit_in,
  output logic pred,
  output logic hist_zero
);

  logic [Length:1]        hist_q, hist_d;
  logic [Length:1]        taps_idx;
  logic [LfsrMaxLength:1] hist_ext, taps_ext;

  // Re-index the ascending tap vector so taps_idx[m] pairs with hist_q[m].
  for (genvar m = 1; m <= Length; m++) begin : g_taps
    assign taps_idx[m] = Tap_Coefficient[m];
  end

  always_comb begin
    hist_ext           = '0;
    taps_ext           = '0;
    hist_ext[Length:1] = hist_q;
    taps_ext[Length:1] = taps_idx;
  end

  assign pred      = lfsr_predict(hist_ext, taps_ext, Length);
  assign hist_zero = (hist_q == '0);

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d = {hist_q[Length-1:1], (use_pred ? pred : bit_in)};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Self-synchronising checker for the serial output of the Galois LFSR generator.
// Fills, hunts for a run of correct predictions, then flywheels and counts errors.
module lfsr_sequence_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned     Length          = LfsrLength,
  parameter logic [1:Length] Tap_Coefficient = LfsrTaps,
  parameter int unsigned     Lock_Count      = 16,
  parameter int unsigned     Window          = 64,
  parameter int unsigned     Loss_Limit      = 8,
  parameter int unsigned     Count_Width     = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   err_clr,
  output logic                   locked,
  output logic                   err_pulse,
  output logic                   sync_loss,
  output logic [Count_Width-1:0] err_count
);

  localparam int unsigned FillW     = $clog2(Length + 1);
  localparam int unsigned MatchW    = $clog2(Lock_Count + 1);
  localparam int unsigned WinW      = $clog2(Window + 1);
  localparam int unsigned WinErrMax = (Loss_Limit > Window) ? Loss_Limit : Window;
  localparam int unsigned WinErrW   = $clog2(WinErrMax + 1);

  lfsr_state_e              state_q, state_d;
  logic [FillW-1:0]         fill_cnt_q, fill_cnt_d;
  logic [MatchW-1:0]        match_cnt_q, match_cnt_d;
  logic [WinW-1:0]          win_cnt_q, win_cnt_d;
  logic [WinErrW-1:0]       win_err_q, win_err_d, win_err_base;
  logic [Count_Width-1:0]   err_count_q, err_count_d;
  logic                     err_pulse_q, err_pulse_d;
  logic                     sync_loss_q, sync_loss_d;
  logic                     win_wrap;
  logic                     pred, hist_zero, mismatch;

  lfsr_history_predictor #(
    .Length          (Length),
    .Tap_Coefficient (Tap_Coefficient)
  ) u_hist (
    .Clock     (Clock),
    .Reset     (Reset),
    .shift_en  (bit_valid),
    .use_pred  (state_q == StLocked),
    .bit_in    (bit_in),
    .pred      (pred),
    .hist_zero (hist_zero)
  );

  assign mismatch = bit_in ^ pred;

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    match_cnt_d  = match_cnt_q;
    win_cnt_d    = win_cnt_q;
    win_err_d    = win_err_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    sync_loss_d  = 1'b0;
    win_wrap     = (win_cnt_q == WinW'(Window - 1));
    win_err_base = win_wrap ? '0 : win_err_q;

    if (bit_valid) begin
      unique case (state_q)
        StFill: begin
          if (fill_cnt_q == FillW'(Length - 1)) begin
            state_d     = StHunt;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        StHunt: begin
          // An all-zero history predicts zero forever, so a stuck-low line must not lock.
          if (!mismatch && !hist_zero) begin
            if (match_cnt_q == MatchW'(Lock_Count - 1)) begin
              state_d   = StLocked;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        StLocked: begin
          win_cnt_d = win_wrap ? '0 : win_cnt_q + 1'b1;
          // The wrapping sample opens the new window, so its error lands there.
          win_err_d = win_err_base + WinErrW'(mismatch);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (win_err_d == WinErrW'(Loss_Limit)) begin
              sync_loss_d = 1'b1;
              state_d     = StFill;
              fill_cnt_d  = '0;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end

    if (err_clr) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StFill;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign sync_loss = sync_loss_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Scoreboard bench: two checkers (default, and 4-bit counter with loss disabled) share
// one stimulus stream; a behavioural model queues expected outputs for a monitor.
module tb_lfsr_sequence_checker;

  localparam int unsigned L     = 8;
  localparam int unsigned LockN = 16;
  localparam int unsigned Win   = 64;
  localparam int unsigned LossA = 8;
  localparam int unsigned LossB = 65;
  localparam int unsigned CwA   = 16;
  localparam int unsigned CwB   = 4;
  localparam int ModeFill   = 0;
  localparam int ModeHunt   = 1;
  localparam int ModeLocked = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic err_clr = 1'b0;
  logic locked_a, err_pulse_a, sync_loss_a;
  logic locked_b, err_pulse_b, sync_loss_b;
  logic [CwA-1:0] err_count_a;
  logic [CwB-1:0] err_count_b;

  always #5 Clock = ~Clock;

  lfsr_sequence_checker #(
    .Length(L), .Tap_Coefficient(8'b1100_1111), .Lock_Count(LockN),
    .Window(Win), .Loss_Limit(LossA), .Count_Width(CwA)
  ) dut_a (
    .Clock(Clock), .Reset(Reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .err_clr(err_clr), .locked(locked_a), .err_pulse(err_pulse_a),
    .sync_loss(sync_loss_a), .err_count(err_count_a)
  );

  lfsr_sequence_checker #(
    .Length(L), .Tap_Coefficient(8'b1100_1111), .Lock_Count(LockN),
    .Window(Win), .Loss_Limit(LossB), .Count_Width(CwB)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .err_clr(err_clr), .locked(locked_b), .err_pulse(err_pulse_b),
    .sync_loss(sync_loss_b), .err_count(err_count_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:L] taps;
  bit gen_hist[L];
  bit hist[2][L];
  int mode[2], filled[2], streak[2], win_pos[2], win_errs[2], errs[2];
  bit pulse[2], loss[2];

  function automatic int loss_of(int k);
    return (k == 0) ? LossA : LossB;
  endfunction

  function automatic int max_of(int k);
    return (k == 0) ? ((1 << CwA) - 1) : ((1 << CwB) - 1);
  endfunction

  // Next bit of the generator's output: y[n] = y[n-L] ^ XOR taps[m]*y[n-m].
  function automatic bit gen_next();
    bit nb;
    nb = gen_hist[L-1];
    for (int m = 1; m < L; m++) if (taps[m]) nb ^= gen_hist[m-1];
    for (int a = L - 1; a > 0; a--) gen_hist[a] = gen_hist[a-1];
    gen_hist[0] = nb;
    return nb;
  endfunction

  function automatic bit ref_pred(int k);
    bit p;
    p = hist[k][L-1];
    for (int m = 1; m < L; m++) if (taps[m]) p ^= hist[k][m-1];
    return p;
  endfunction

  function automatic void model_reset(int k);
    for (int a = 0; a < L; a++) hist[k][a] = 1'b0;
    mode[k] = ModeFill; filled[k] = 0; streak[k] = 0;
    win_pos[k] = 0; win_errs[k] = 0; errs[k] = 0;
    pulse[k] = 1'b0; loss[k] = 1'b0;
  endfunction

  function automatic void model_step(int k, bit v, bit b, bit clr);
    bit p, any_one, bad;
    int old_mode;
    pulse[k] = 1'b0;
    loss[k]  = 1'b0;
    if (v) begin
      p = ref_pred(k);
      any_one = 1'b0;
      for (int a = 0; a < L; a++) any_one |= hist[k][a];
      bad = (b != p);
      old_mode = mode[k];
      if (old_mode == ModeFill) begin
        filled[k]++;
        if (filled[k] == L) begin mode[k] = ModeHunt; streak[k] = 0; end
      end else if (old_mode == ModeHunt) begin
        streak[k] = (!bad && any_one) ? streak[k] + 1 : 0;
        if (streak[k] == LockN) begin
          mode[k] = ModeLocked; win_pos[k] = 0; win_errs[k] = 0;
        end
      end else begin
        win_pos[k]++;
        if (win_pos[k] == Win) begin win_pos[k] = 0; win_errs[k] = 0; end
        if (bad) begin
          pulse[k] = 1'b1;
          if (errs[k] < max_of(k)) errs[k]++;
          win_errs[k]++;
          if (win_errs[k] == loss_of(k)) begin
            loss[k] = 1'b1; mode[k] = ModeFill; filled[k] = 0;
          end
        end
      end
      for (int a = L - 1; a > 0; a--) hist[k][a] = hist[k][a-1];
      hist[k][0] = (old_mode == ModeLocked) ? p : b;
    end
    if (clr) errs[k] = 0;
  endfunction

  typedef struct packed {
    logic la, pa, sa;
    logic [CwA-1:0] ca;
    logic lb, pb, sb;
    logic [CwB-1:0] cb;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t snapshot();
    exp_t e;
    e.la = (mode[0] == ModeLocked); e.pa = pulse[0]; e.sa = loss[0]; e.ca = CwA'(errs[0]);
    e.lb = (mode[1] == ModeLocked); e.pb = pulse[1]; e.sb = loss[1]; e.cb = CwB'(errs[1]);
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_locked_a", locked_a, e.la);
        check("sb_err_pulse_a", err_pulse_a, e.pa);
        check("sb_sync_loss_a", sync_loss_a, e.sa);
        check("sb_err_count_a", err_count_a, e.ca);
        check("sb_locked_b", locked_b, e.lb);
        check("sb_err_pulse_b", err_pulse_b, e.pb);
        check("sb_sync_loss_b", sync_loss_b, e.sb);
        check("sb_err_count_b", err_count_b, e.cb);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit v, input bit b, input bit clr);
    bit_valid = v;
    bit_in    = b;
    err_clr   = clr;
    for (int k = 0; k < 2; k++) model_step(k, v, b, clr);
    exp_q.push_back(snapshot());
    @(negedge Clock);
  endtask

  task automatic send(input bit flip, input bit clr);
    drive(1'b1, gen_next() ^ flip, clr);
  endtask

  task automatic do_reset();
    #2;
    Reset = 1'b0;
    bit_valid = 1'b0;
    err_clr = 1'b0;
    for (int k = 0; k < 2; k++) model_reset(k);
    exp_q.push_back(snapshot());
    #1;
    check("reset_locked_a", locked_a, 0);
    check("reset_err_count_a", err_count_a, 0);
    check("reset_locked_b", locked_b, 0);
    check("reset_err_count_b", err_count_b, 0);
    @(negedge Clock);
    exp_q.push_back(snapshot());
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit flips[40];
    int n, p;
    bit seen;
    logic [7:0] seed;
    taps = 8'b1100_1111;
    seed = 8'h91;
    for (int a = 0; a < L; a++) gen_hist[a] = seed[a];
    for (int k = 0; k < 2; k++) model_reset(k);

    @(negedge Clock);
    do_reset();

    // Clean stream: lock after exactly 24 valid bits, no errors.
    for (int i = 1; i <= 2000; i++) begin
      send(1'b0, 1'b0);
      if (i == 23) begin
        check("lock_a_before_24", locked_a, 0);
        check("lock_b_before_24", locked_b, 0);
      end
      if (i == 24) begin
        check("lock_a_at_24", locked_a, 1);
        check("lock_b_at_24", locked_b, 1);
      end
    end
    check("clean_err_count_a", err_count_a, 0);
    check("clean_err_count_b", err_count_b, 0);

    // Single inverted bit.
    repeat ($urandom_range(60, 5)) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("single_err_pulse_a", err_pulse_a, 1);
    repeat (200) send(1'b0, 1'b0);
    check("single_err_count_a", err_count_a, 1);
    check("single_err_count_b", err_count_b, 1);
    check("single_err_locked_a", locked_a, 1);

    // Random valid gaps, sparse errors, occasional clears; junk on idle cycles.
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 3) != 0) drive(1'b1, gen_next() ^ ($urandom % 120 == 0),
                                     ($urandom % 80) == 0);
      else drive(1'b0, 1'($urandom), ($urandom % 80) == 0);
    end

    // Eight errors in 40 bits inside one window forces sync loss on the 8th.
    for (int g = 0; g < 300; g++) begin
      if (mode[0] == ModeLocked && mode[1] == ModeLocked) break;
      send(1'b0, 1'b0);
    end
    check("burst_pre_locked_a", locked_a, 1);
    send(1'b0, 1'b1);
    for (int g = 0; g < Win; g++) begin
      if (win_pos[0] == 0) break;
      send(1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) flips[i] = 1'b0;
    flips[39] = 1'b1;
    n = 0;
    while (n < 7) begin
      p = $urandom_range(38, 0);
      if (!flips[p]) begin flips[p] = 1'b1; n++; end
    end
    for (int i = 0; i < 40; i++) send(flips[i], 1'b0);
    check("burst_sync_loss_a", sync_loss_a, 1);
    check("burst_unlocked_a", locked_a, 0);
    check("burst_locked_b", locked_b, 1);
    for (int j = 1; j <= 24; j++) begin
      send(1'b0, 1'b0);
      if (j == 23) check("relock_a_before_24", locked_a, 0);
      if (j == 24) check("relock_a_at_24", locked_a, 1);
    end
    check("burst_err_count_a", err_count_a, 8);
    check("burst_err_count_b", err_count_b, 8);

    // Stuck-low line never locks.
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      seen |= locked_a | locked_b;
    end
    check("zeros_never_lock", seen, 0);
    check("zeros_err_count_a", err_count_a, 0);

    // One valid cycle in three.
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      drive(1'b0, 1'($urandom), 1'b0);
      drive(1'b0, 1'($urandom), 1'b0);
      send(1'b0, 1'b0);
      if (c == 23) check("sparse_lock_before_24", locked_a | locked_b, 0);
      if (c == 24) begin
        check("sparse_lock_a_at_24", locked_a, 1);
        check("sparse_lock_b_at_24", locked_b, 1);
      end
    end

    // Saturation of the 4-bit counter, then clear coincident with an error.
    for (int e = 0; e < 20; e++) begin
      repeat (4) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
    end
    check("sat_err_count_b", err_count_b, 15);
    check("sat_locked_b", locked_b, 1);
    send(1'b1, 1'b1);
    check("clr_wins_err_count_b", err_count_b, 0);
    check("clr_wins_pulse_b", err_pulse_b, 1);
    check("clr_wins_err_count_a", err_count_a, 0);

    // Asynchronous reset while locked with a non-zero count, then relock.
    repeat (100) send(1'b0, 1'b0);
    check("prereset_locked_a", locked_a, 1);
    send(1'b1, 1'b0);
    check("prereset_err_count_a", err_count_a, 1);
    do_reset();
    for (int j = 1; j <= 24; j++) begin
      send(1'b0, 1'b0);
      if (j == 23) check("postreset_lock_before_24", locked_a | locked_b, 0);
      if (j == 24) begin
        check("postreset_lock_a_at_24", locked_a, 1);
        check("postreset_lock_b_at_24", locked_b, 1);
      end
    end
    repeat (20) send(1'b0, 1'b0);

    bit_valid = 1'b0;
    repeat (3) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
